// File: rtl/moving_avg_pkg.sv
// Shared types and elaboration helpers for the moving-average filter.
// Holds the FSM state enum, the running-sum width function and the
// legal parameter ranges checked when moving_avg_n elaborates.
package moving_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 16;
  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 16;

  // Width of the running sum: DEPTH samples of DATA_W bits never overflow it.
  function automatic int sum_w(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/moving_avg_if.sv
// Sample-in / average-out bus of the moving-average filter.
//
// Handshake: each direction is a valid/ready pair. A transfer happens on a
// rising clock edge where valid and ready are both high. Once valid is
// raised, it and its data stay stable until the transfer happens; only a
// clear or a reset may withdraw it. Ready never depends combinationally on
// the valid of the same pair.
interface moving_avg_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     valid_i;
  logic                     ready_o;
  logic signed [DATA_W-1:0] sample_i;
  logic                     valid_o;
  logic                     ready_i;
  logic signed [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]         count_o;

  // The filter side.
  modport slave (
    input  valid_i, sample_i, ready_i,
    output ready_o, valid_o, data_o, count_o
  );

  // The sampler/consumer side.
  modport master (
    output valid_i, sample_i, ready_i,
    input  ready_o, valid_o, data_o, count_o
  );

endinterface

// File: rtl/seq_sdiv.sv
// W-bit signed iterative divider: restoring division on magnitudes, one
// quotient bit per clock, sign applied at the end (truncates toward zero).
// start_i loads the operands and already performs the first step, so the
// registered quotient and a one-cycle done_o pulse appear W cycles after
// the start cycle. clear_i aborts an operation in flight.
module seq_sdiv #(
  parameter int W = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic signed [W-1:0] dividend_i,
  input  logic signed [W-1:0] divisor_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     den_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     quot_q;

  logic [W-1:0] a_u;
  logic [W-1:0] b_u;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic         neg_in;
  logic [W-1:0] rem_in;
  logic [W-1:0] quo_in;
  logic [W-1:0] den_in;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic [W-1:0] rem_nx;
  logic [W-1:0] quo_nx;
  logic [W-1:0] quo_signed;

  assign a_u   = dividend_i;
  assign b_u   = divisor_i;
  // The most negative dividend maps to 2^(W-1), which still fits unsigned.
  assign abs_a = a_u[W-1] ? (~a_u + W'(1)) : a_u;
  assign abs_b = b_u[W-1] ? (~b_u + W'(1)) : b_u;

  // One restoring step, fed from fresh operands on start or from the registers.
  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    den_in = den_q;
    neg_in = neg_q;
    if (start_i) begin
      rem_in = '0;
      quo_in = abs_a;
      den_in = abs_b;
      neg_in = a_u[W-1] ^ b_u[W-1];
    end
    shifted = {rem_in, quo_in[W-1]};
    diff    = shifted - {1'b0, den_in};
    if (!diff[W]) begin
      rem_nx = diff[W-1:0];
      quo_nx = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_nx = shifted[W-1:0];
      quo_nx = {quo_in[W-2:0], 1'b0};
    end
    quo_signed = neg_in ? (~quo_nx + W'(1)) : quo_nx;
  end

  // Iteration registers, step counter and the done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        den_q  <= den_in;
        neg_q  <= neg_in;
        cnt_q  <= CNT_W'(W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          quot_q <= quo_signed;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quot_q;

endmodule

// File: rtl/moving_avg_n.sv
// Handshaked moving-average filter over the last DEPTH signed samples.
// A circular buffer and a running sum are updated on every accepted sample;
// the average is produced by seq_sdiv and held on data_o until consumed.
// Optional feature macro: MOVAVG_WARMUP_EN. When defined, every sample
// yields an output and the divisor is the current fill count; otherwise
// output starts once the window is full and the divisor is always DEPTH.
module moving_avg_n
  import moving_avg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  moving_avg_if.slave  bus,
  output logic [1:0]   state_o
);

  localparam int SUM_W = sum_w(DATA_W, DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DIV  = ST_DIV;
  localparam logic [1:0] OUT  = ST_OUT;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("moving_avg_n: DATA_W must be within 4..16");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("moving_avg_n: DEPTH must be within 2..16");
  end

  logic [1:0]               state_q;
  logic signed [DATA_W-1:0] buffer_q [DEPTH];
  logic signed [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]         count_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic signed [DATA_W-1:0] data_q;

  logic                     accept;
  logic                     full;
  logic signed [DATA_W-1:0] oldest;
  logic signed [SUM_W-1:0]  sample_ext;
  logic signed [SUM_W-1:0]  oldest_ext;
  logic signed [SUM_W-1:0]  sum_nx;
  logic [CNT_W-1:0]         count_nx;
  logic [PTR_W-1:0]         wr_ptr_nx;
  logic                     go_div;
  logic                     div_start;
  logic signed [SUM_W-1:0]  divisor;
  logic                     div_busy;
  logic                     div_done;
  logic signed [SUM_W-1:0]  div_quot;

  // Window bookkeeping for the sample that would be accepted this cycle.
  always_comb begin
    accept     = (state_q == IDLE) && !div_busy && bus.valid_i;
    full       = (count_q == CNT_W'(DEPTH));
    oldest     = buffer_q[wr_ptr_q];
    sample_ext = {{(SUM_W - DATA_W){bus.sample_i[DATA_W-1]}}, bus.sample_i};
    oldest_ext = {{(SUM_W - DATA_W){oldest[DATA_W-1]}}, oldest};
    // Once the window is full the slot about to be overwritten leaves the sum.
    sum_nx     = sum_q + sample_ext - (full ? oldest_ext : '0);
    count_nx   = full ? count_q : count_q + CNT_W'(1);
    wr_ptr_nx  = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
`ifdef MOVAVG_WARMUP_EN
    go_div     = 1'b1;
    divisor    = {{(SUM_W - CNT_W){1'b0}}, count_nx};
`else
    go_div     = (count_nx == CNT_W'(DEPTH));
    divisor    = SUM_W'(DEPTH);
`endif
    div_start  = accept && go_div && !clear_i;
  end

  seq_sdiv #(
    .W (SUM_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (div_start),
    .dividend_i (sum_nx),
    .divisor_i  (divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // FSM, running sum, fill count, write pointer and the held result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      data_q   <= '0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_q    <= sum_nx;
            count_q  <= count_nx;
            wr_ptr_q <= wr_ptr_nx;
            state_q  <= go_div ? DIV : IDLE;
          end
        end
        DIV: begin
          // The average always fits DATA_W, so the low bits are the result.
          if (div_done) begin
            data_q  <= DATA_W'(div_quot);
            state_q <= OUT;
          end
        end
        OUT: begin
          if (bus.ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample storage; cleared slots are ignored because count gates their use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        buffer_q[i] <= '0;
      end
    end else if (!clear_i && accept) begin
      buffer_q[wr_ptr_q] <= bus.sample_i;
    end
  end

  assign bus.ready_o = (state_q == IDLE) && !div_busy;
  assign bus.valid_o = (state_q == OUT);
  assign bus.data_o  = data_q;
  assign bus.count_o = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_moving_avg_n.sv
// Bench for moving_avg_n (DATA_W=8, DEPTH=3): directed cases plus random
// samples, checked against a queue-based window average model.
module tb_moving_avg_n;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int SUM_W  = DATA_W + $clog2(DEPTH);

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [1:0] state;

  moving_avg_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  moving_avg_n #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus),
    .state_o (state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total;
  int bad;
  int win_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: average of the last DEPTH accepted samples, truncated toward zero.
  task automatic model_push(input int s, output bit has_out, output int avg);
    int tot;
    win_q.push_back(s);
    if (win_q.size() > DEPTH) void'(win_q.pop_front());
    tot = 0;
    foreach (win_q[i]) tot += win_q[i];
`ifdef MOVAVG_WARMUP_EN
    has_out = 1'b1;
`else
    has_out = (win_q.size() == DEPTH);
`endif
    avg = tot / int'(win_q.size());
  endtask

  task automatic offer_and_accept(input int s);
    int n;
    bus.valid_i  = 1'b1;
    bus.sample_i = DATA_W'(s);
    n = 0;
    while (!bus.ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic do_sample(input int s, input int hold, input bit offer, input int offer_s);
    int  avg;
    bit  has_out;
    int  lat;
    model_push(s, has_out, avg);
    offer_and_accept(s);
    check("count", int'(bus.count_o), win_q.size());
    if (has_out) begin
      check("ready_in_div", int'(bus.ready_o), 0);
      lat = 0;
      while (!bus.valid_o && lat < 100) begin
        tick();
        lat++;
      end
      check("latency", lat, SUM_W);
      check("data", int'(bus.data_o), avg);
      for (int i = 0; i < hold; i++) begin
        if (offer) begin
          bus.valid_i  = 1'b1;
          bus.sample_i = DATA_W'(offer_s);
        end
        tick();
        check("hold_valid", int'(bus.valid_o), 1);
        check("hold_data", int'(bus.data_o), avg);
        check("hold_ready", int'(bus.ready_o), 0);
        check("hold_count", int'(bus.count_o), win_q.size());
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      check("post_valid", int'(bus.valid_o), 0);
      check("post_ready", int'(bus.ready_o), 1);
    end else begin
      check("skip_valid", int'(bus.valid_o), 0);
      check("skip_ready", int'(bus.ready_o), 1);
    end
  endtask

  task automatic flush();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    win_q.delete();
    check("flush_count", int'(bus.count_o), 0);
    check("flush_valid", int'(bus.valid_o), 0);
  endtask

  task automatic clear_during_div(input int s);
    bit seen;
    offer_and_accept(s);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    win_q.delete();
    check("cdiv_count", int'(bus.count_o), 0);
    check("cdiv_ready", int'(bus.ready_o), 1);
    seen = 1'b0;
    for (int i = 0; i < SUM_W + 4; i++) begin
      if (bus.valid_o) seen = 1'b1;
      tick();
    end
    check("cdiv_no_out", int'(seen), 0);
  endtask

  task automatic reset_mid_out(input int s);
    int  avg;
    bit  has_out;
    int  n;
    model_push(s, has_out, avg);
    offer_and_accept(s);
    n = 0;
    while (!bus.valid_o && n < 100) begin
      tick();
      n++;
    end
    check("rst_reach_out", int'(bus.valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ready", int'(bus.ready_o), 1);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_data", int'(bus.data_o), 0);
    check("rst_count", int'(bus.count_o), 0);
    win_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Stimulus
  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.sample_i = '0;
    #2;
    check("reset_ready", int'(bus.ready_o), 1);
    check("reset_valid", int'(bus.valid_o), 0);
    check("reset_data", int'(bus.data_o), 0);
    check("reset_count", int'(bus.count_o), 0);
    check("reset_state", int'(state), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Window fill and slide: 10,20,30,60,90
    do_sample(10, 0, 1'b0, 0);
    do_sample(20, 0, 1'b0, 0);
    do_sample(30, 0, 1'b0, 0);
    do_sample(60, 0, 1'b0, 0);
    do_sample(90, 0, 1'b0, 0);
    flush();

    // Signed truncation toward zero
    do_sample(-7, 0, 1'b0, 0);
    do_sample(-8, 0, 1'b0, 0);
    flush();

    // Most negative samples, then backpressure with a sample waiting
    do_sample(-128, 0, 1'b0, 0);
    do_sample(-128, 0, 1'b0, 0);
    do_sample(-128, 5, 1'b1, 99);
    do_sample(99, 2, 1'b0, 0);
    do_sample(127, 0, 1'b0, 0);

    reset_mid_out(-50);

    clear_during_div(55);
    do_sample(40, 0, 1'b0, 0);
    do_sample(40, 0, 1'b0, 0);
    do_sample(40, 1, 1'b0, 0);

    // Random samples, backpressure and occasional flushes
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush();
      end else begin
        do_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)), 1'b0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
